// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// Holds the FSM state encoding and the counter-width helper so the top
// and any future users agree on both.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Bit-position counter width; WIDTH >= 2 is required, so the
  // guard only keeps a zero-width vector from ever being formed.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder_ha.sv
// Purpose: combinational 1-bit full adder made of two half adders and an OR.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake, output follows inputs.
// Ports: a, b, ci - addend bits and carry-in; s - sum bit; co - carry-out.
module full_adder_ha (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  // First half adder: a + b
  assign s1 = a ^ b;
  assign c1 = a & b;

  // Second half adder: partial sum + carry-in
  assign s  = s1 ^ ci;
  assign c2 = s1 & ci;

  // At most one of the two half-adder carries can be set.
  assign co = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Purpose: bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Latency: done pulses WIDTH cycles after the accepting edge; busy for WIDTH+1.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
// Ports: clk, rst (async active-high); start, A, B (Cin with SERIAL_ADDER_CIN_EN)
//        in; busy (state != IDLE), done (1-cycle pulse), Sum, Carry out.
// Optional feature: define SERIAL_ADDER_CIN_EN to add the Cin port.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_CIN_EN
  input  logic             Cin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sha;
  logic [WIDTH-1:0] shb;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;
  logic             cin_init;

`ifdef SERIAL_ADDER_CIN_EN
  assign cin_init = Cin;
`else
  assign cin_init = 1'b0;
`endif

  full_adder_ha u_fa (
    .a  (sha[0]),
    .b  (shb[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sha   <= '0;
      shb   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      Sum   <= '0;
      Carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sha   <= A;
            shb   <= B;
            carry <= cin_init;
            cnt   <= '0;
            state <= RUN;
          end
        end

        RUN: begin
          sha   <= {1'b0, sha[WIDTH-1:1]};
          shb   <= {1'b0, shb[WIDTH-1:1]};
          // Result bits enter at the MSB so that after WIDTH shifts bit 0
          // has walked down to Sum[0]; Sum is never cleared on start.
          Sum   <= {fa_s, Sum[WIDTH-1:1]};
          carry <= fa_co;
          if (cnt == LAST) begin
            // Clear explicitly: for non-power-of-two WIDTH the increment
            // would not wrap on its own.
            cnt   <= '0;
            Carry <= fa_co;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: behavioural model + directed and random stimulus.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
`ifdef SERIAL_ADDER_CIN_EN
  logic         Cin = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] Sum;
  logic         Carry;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
`ifdef SERIAL_ADDER_CIN_EN
    .Cin   (Cin),
`endif
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Carry (Carry)
  );

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic cin_now();
`ifdef SERIAL_ADDER_CIN_EN
    return Cin;
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_cin(input logic c);
`ifdef SERIAL_ADDER_CIN_EN
    Cin = c;
`else
    if (c) $display("note: carry-in ignored in this build");
`endif
  endtask

  // ---------------- behavioural model ----------------
  // ph = clock edges elapsed since the accepting edge (0 = idle);
  // ph = W+1 is the single done cycle.
  int              ph = 0;
  longint unsigned res = 0;      // full (W+1)-bit arithmetic result
  longint unsigned old_sum = 0;  // Sum value at the time of acceptance
  longint unsigned m_sum = 0;    // last completed Sum
  logic            m_carry = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0; res = 0; old_sum = 0; m_sum = 0; m_carry = 1'b0;
    end else begin
      if (ph == 0) begin
        if (start) begin
          ph      = 1;
          res     = longint'(A) + longint'(B) + longint'(cin_now());
          old_sum = m_sum;
        end
      end else if (ph <= W) begin
        ph++;
      end else begin
        ph = 0;
      end
      if (ph == W + 1) begin
        m_sum   = res & ((64'd1 << W) - 1);
        m_carry = res[W];
      end
    end
  end

  // After k serial steps the k low result bits sit in the top of Sum and
  // the previous Sum has moved down by k.
  function automatic longint unsigned exp_sum();
    int k;
    longint unsigned lo;
    if (ph == 0) return m_sum;
    k  = ph - 1;
    lo = res & ((64'd1 << k) - 1);
    return ((old_sum >> k) | (lo << (W - k))) & ((64'd1 << W) - 1);
  endfunction

  always @(negedge clk) begin
    chk("busy", busy, (ph != 0));
    chk("done", done, (ph == W + 1));
    chk("Sum", Sum, exp_sum());
    chk("Carry", Carry, m_carry);
  end

  // ---------------- directed helpers ----------------
  task automatic wait_idle(input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) begin
        seen = 1;
        break;
      end
    end
    chk({name, "_idle_timeout"}, seen, 1);
  endtask

  task automatic add(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic c, input logic [W-1:0] esum, input logic ecarry);
    int lat;
    int nb;
    A = a; B = b; set_cin(c); start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0; A = W'($urandom); B = W'($urandom);
    lat = -1;
    nb  = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done && lat < 0) lat = i - 1;
      if (busy) nb++;
      else break;
    end
    chk({name, "_latency"}, longint'(lat), W);
    chk({name, "_busy_cycles"}, nb, W + 1);
    chk({name, "_sum"}, Sum, esum);
    chk({name, "_carry"}, Carry, ecarry);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones[$];
    int ok;
    set_cin(1'b0);
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", Sum, 0);
    chk("rst_carry", Carry, 0);
    rst = 1'b0;
    @(negedge clk);

    add("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    add("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    add("a5_5a", 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0);

    // Held start: back-to-back accepts every W+2 cycles, 1-cycle done.
    A = 8'h80; B = 8'h80; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones.push_back(i);
    end
    start = 1'b0;
    chk("held_pulses", (dones.size() >= 3), 1);
    for (int i = 1; i < dones.size(); i++)
      chk("held_spacing", dones[i] - dones[i-1], W + 2);
    wait_idle("held");
    chk("held_sum", Sum, 8'h00);
    chk("held_carry", Carry, 1'b1);

    // start re-asserted mid-run must be ignored.
    A = 8'h01; B = 8'h01; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 start = 1'b1; A = 8'hF0; B = 8'hF0;
    @(posedge clk);
    #2 start = 1'b0;
    wait_idle("ignore");
    chk("ignore_sum", Sum, 8'h02);
    chk("ignore_carry", Carry, 1'b0);

    // Reset in the middle of a run.
    A = 8'h7F; B = 8'h01; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sum", Sum, 0);
    chk("midrst_carry", Carry, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    add("after_rst", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0);

`ifdef SERIAL_ADDER_CIN_EN
    add("cin_ff_00", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    add("cin_10_20", 8'h10, 8'h20, 1'b1, 8'h31, 1'b0);
`endif

    // Random traffic: random start noise and operands, model checks every cycle.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      start = 1'($urandom_range(0, 1));
      A = W'($urandom);
      B = W'($urandom);
      set_cin(1'($urandom_range(0, 1)));
    end
    start = 1'b0;
    wait_idle("random");
    ok = (Sum == W'(m_sum)) ? 1 : 0;
    chk("random_final_sum", ok, 1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
